// File: rtl/obstacle_spawn_scheduler.sv
// Paces asteroid spawns once per video frame. It picks the lowest free obstacle slot
// and offers it, with a random payload, to the obstacle datapath over valid/ready.
module obstacle_spawn_scheduler #(
  parameter int OBJ_NUM       = 17,
  parameter int INIT_INTERVAL = 60,
  parameter int MIN_INTERVAL  = 8,
  parameter int INTERVAL_STEP = 4,
  parameter int STEP_SCORE    = 10,
  parameter int X_LIMIT       = 600
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               game_screen,
  input  logic               clear,
  input  logic [OBJ_NUM-1:0] obj_active,
  input  logic [23:0]        score,
  input  logic [31:0]        rand_i,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [4:0]         spawn_idx,
  output logic [9:0]         spawn_x,
  output logic [2:0]         spawn_xspeed,
  output logic [2:0]         spawn_yspeed,
  output logic               spawn_sign,
  output logic [7:0]         interval,
  output logic [15:0]        spawn_count
);

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, ISSUE} state_e;

  localparam logic [7:0]  INIT_IV = 8'(INIT_INTERVAL);
  localparam logic [7:0]  MIN_IV  = 8'(MIN_INTERVAL);
  localparam logic [7:0]  STEP_IV = 8'(INTERVAL_STEP);
  localparam logic [24:0] STEP_SC = 25'(STEP_SCORE);
  localparam logic [9:0]  X_LIM   = 10'(X_LIMIT);

  state_e      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic [7:0]  fcnt_q;
  logic [7:0]  interval_q;
  logic [24:0] thresh_q;
  logic [15:0] count_q;
  logic        valid_q;
  logic [4:0]  idx_q;
  logic [9:0]  x_q;
  logic [2:0]  xspeed_q;
  logic [2:0]  yspeed_q;
  logic        sign_q;

  logic        tick;
  logic        levelUp;
  logic        freeFound_d;
  logic [4:0]  freeIdx_d;
  logic [9:0]  x_d;
  logic [7:0]  interval_d;
  logic        unused_rand;

  assign tick        = sync2_q & ~sync3_q;
  assign levelUp     = {1'b0, score} >= thresh_q;
  assign interval_d  = (interval_q >= MIN_IV + STEP_IV) ? interval_q - STEP_IV : MIN_IV;
  // Out-of-range x folds back by 512 so every raw value lands on screen.
  assign x_d         = (rand_i[9:0] < X_LIM) ? rand_i[9:0] : rand_i[9:0] - 10'd512;
  assign unused_rand = ^rand_i[31:16];

  always_comb begin
    freeFound_d = 1'b0;
    freeIdx_d   = 5'd0;
    for (int i = OBJ_NUM - 1; i >= 0; i--) begin
      if (!obj_active[i]) begin
        freeFound_d = 1'b1;
        freeIdx_d   = 5'(i);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      fcnt_q     <= 8'd0;
      interval_q <= INIT_IV;
      thresh_q   <= STEP_SC;
      count_q    <= 16'd0;
      valid_q    <= 1'b0;
      idx_q      <= 5'd0;
      x_q        <= 10'd0;
      xspeed_q   <= 3'd0;
      yspeed_q   <= 3'd0;
      sign_q     <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (clear) begin
        state_q    <= IDLE;
        valid_q    <= 1'b0;
        fcnt_q     <= 8'd0;
        interval_q <= INIT_IV;
        thresh_q   <= STEP_SC;
        count_q    <= 16'd0;
      end else begin
        if (levelUp) begin
          thresh_q   <= thresh_q + STEP_SC;
          interval_q <= interval_d;
        end
        if (!game_screen) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end else begin
          case (state_q)
            IDLE: state_q <= WAIT;
            WAIT: begin
              if (tick && fcnt_q != 8'hFF) fcnt_q <= fcnt_q + 8'd1;
              if (fcnt_q >= interval_q) state_q <= SCAN;
            end
            SCAN: begin
              // A full array goes back to WAIT with fcnt kept, so it rescans every 2 cycles.
              if (freeFound_d) begin
                idx_q    <= freeIdx_d;
                x_q      <= x_d;
                xspeed_q <= {1'b0, rand_i[14:13]};
                yspeed_q <= {1'b0, rand_i[12:11]} + 3'd1;
                sign_q   <= rand_i[15];
                valid_q  <= 1'b1;
                state_q  <= ISSUE;
              end else begin
                state_q <= WAIT;
              end
            end
            ISSUE: begin
              if (spawn_ready) begin
                valid_q <= 1'b0;
                fcnt_q  <= 8'd0;
                count_q <= count_q + 16'd1;
                state_q <= WAIT;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign spawn_valid  = valid_q;
  assign spawn_idx    = idx_q;
  assign spawn_x      = x_q;
  assign spawn_xspeed = xspeed_q;
  assign spawn_yspeed = yspeed_q;
  assign spawn_sign   = sign_q;
  assign interval     = interval_q;
  assign spawn_count  = count_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Self-checking bench for obstacle_spawn_scheduler: directed scenarios plus random
// traffic, compared every cycle against a frame-level reference model.
module tb_obstacle_spawn_scheduler;

  localparam int OBJ_NUM = 17;
  localparam int FRAME_P = 4;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               frame_clk = 1'b0;
  logic               game_screen = 1'b0;
  logic               clear = 1'b0;
  logic [OBJ_NUM-1:0] obj_active = '0;
  logic [23:0]        score = 24'd0;
  logic [31:0]        rand_i = 32'd0;
  logic               spawn_ready = 1'b0;
  logic               spawn_valid;
  logic [4:0]         spawn_idx;
  logic [9:0]         spawn_x;
  logic [2:0]         spawn_xspeed;
  logic [2:0]         spawn_yspeed;
  logic               spawn_sign;
  logic [7:0]         interval;
  logic [15:0]        spawn_count;

  int compared = 0;
  int mismatched = 0;
  int frameCycle = 0;

  // Reference model: phase 0 idle, 1 counting frames, 2 looking for a slot, 3 offering.
  int mPhase, mFrames, mInterval, mThresh, mAccepted;
  int mValid, mIdx, mX, mXs, mYs, mSign;
  bit fh1, fh2, fh3;

  obstacle_spawn_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .game_screen(game_screen),
    .clear(clear), .obj_active(obj_active), .score(score), .rand_i(rand_i),
    .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_idx(spawn_idx),
    .spawn_x(spawn_x), .spawn_xspeed(spawn_xspeed), .spawn_yspeed(spawn_yspeed),
    .spawn_sign(spawn_sign), .interval(interval), .spawn_count(spawn_count)
  );

  always #10 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    mPhase = 0; mFrames = 0; mInterval = 60; mThresh = 10; mAccepted = 0;
    mValid = 0; mIdx = 0; mX = 0; mXs = 0; mYs = 0; mSign = 0;
    fh1 = 1'b0; fh2 = 1'b0; fh3 = 1'b0;
  endtask

  task automatic modelStep();
    bit tickNow;
    int oldInterval;
    bit due;
    int slot;
    int r;
    tickNow = fh2 && !fh3;
    fh3 = fh2; fh2 = fh1; fh1 = frame_clk;
    if (clear) begin
      mPhase = 0; mValid = 0; mFrames = 0; mInterval = 60; mThresh = 10; mAccepted = 0;
      return;
    end
    oldInterval = mInterval;
    if (int'(score) >= mThresh) begin
      mThresh += 10;
      mInterval = (mInterval - 4 < 8) ? 8 : mInterval - 4;
    end
    if (!game_screen) begin
      mPhase = 0; mValid = 0;
      return;
    end
    case (mPhase)
      0: mPhase = 1;
      1: begin
        due = (mFrames >= oldInterval);
        if (tickNow) mFrames = (mFrames + 1 > 255) ? 255 : mFrames + 1;
        if (due) mPhase = 2;
      end
      2: begin
        slot = -1;
        for (int i = 0; i < OBJ_NUM; i++) if (slot < 0 && obj_active[i] == 1'b0) slot = i;
        if (slot >= 0) begin
          r = int'(rand_i % 1024);
          mIdx = slot;
          mX = (r < 600) ? r : r - 512;
          mXs = int'((rand_i / 8192) % 4);
          mYs = int'((rand_i / 2048) % 4) + 1;
          mSign = int'((rand_i / 32768) % 2);
          mValid = 1;
          mPhase = 3;
        end else begin
          mPhase = 1;
        end
      end
      default: begin
        if (spawn_ready) begin
          mValid = 0; mFrames = 0; mAccepted = (mAccepted + 1) % 65536; mPhase = 1;
        end
      end
    endcase
  endtask

  // One clock cycle: advance the frame pulse, step model and DUT, then compare.
  task automatic applyStimulus();
    frameCycle++;
    frame_clk = ((frameCycle % FRAME_P) < FRAME_P / 2);
    @(posedge Clk);
    modelStep();
    #1;
    checkOutput("valid", spawn_valid, mValid);
    checkOutput("idx", spawn_idx, mIdx);
    checkOutput("x", spawn_x, mX);
    checkOutput("xspeed", spawn_xspeed, mXs);
    checkOutput("yspeed", spawn_yspeed, mYs);
    checkOutput("sign", spawn_sign, mSign);
    checkOutput("interval", interval, mInterval);
    checkOutput("count", spawn_count, mAccepted);
  endtask

  task automatic waitValid(input int bound, input string tag);
    int n;
    n = 0;
    while (spawn_valid !== 1'b1 && n < bound) begin
      applyStimulus();
      n++;
    end
    if (spawn_valid !== 1'b1) checkOutput(tag, 0, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Valid"}, spawn_valid, 0);
    checkOutput({tag, "Idx"}, spawn_idx, 0);
    checkOutput({tag, "X"}, spawn_x, 0);
    checkOutput({tag, "Xs"}, spawn_xspeed, 0);
    checkOutput({tag, "Ys"}, spawn_yspeed, 0);
    checkOutput({tag, "Sign"}, spawn_sign, 0);
    checkOutput({tag, "Interval"}, interval, 60);
    checkOutput({tag, "Count"}, spawn_count, 0);
  endtask

  initial begin
    int gap;
    int sawValid;
    int prevAcc;
    int capX, capIdx;
    int n;

    resetModel();
    repeat (3) @(posedge Clk);
    #1;
    checkResetValues("rst");
    Reset_n = 1'b1;

    $display("[TB] first spawn with fixed random word");
    game_screen = 1'b1; obj_active = '0; spawn_ready = 1'b1; rand_i = 32'h0000_A0C8;
    waitValid(400, "firstSpawnTimeout");
    checkOutput("firstIdx", spawn_idx, 0);
    checkOutput("firstX", spawn_x, 200);
    checkOutput("firstYs", spawn_yspeed, 1);
    checkOutput("firstXs", spawn_xspeed, 1);
    checkOutput("firstSign", spawn_sign, 1);
    applyStimulus();
    checkOutput("firstCount", spawn_count, 1);
    gap = 1;
    while (spawn_valid !== 1'b1 && gap < 400) begin
      applyStimulus();
      gap++;
    end
    checkOutput("spawnGap", (gap >= 238 && gap <= 245), 1);
    applyStimulus();

    $display("[TB] all slots occupied");
    obj_active = '1;
    sawValid = 0;
    for (int i = 0; i < 200 * FRAME_P; i++) begin
      applyStimulus();
      if (spawn_valid === 1'b1) sawValid = 1;
    end
    checkOutput("fullNoSpawn", sawValid, 0);
    obj_active[5] = 1'b0;
    waitValid(4, "slot5Timeout");
    checkOutput("slot5Idx", spawn_idx, 5);
    applyStimulus();
    obj_active = '0;

    $display("[TB] back-pressure with changing random word");
    spawn_ready = 1'b0;
    waitValid(400, "holdTimeout");
    capX = mX; capIdx = mIdx; prevAcc = mAccepted;
    for (int i = 0; i < 50; i++) begin
      rand_i = $urandom;
      applyStimulus();
      checkOutput("holdValid", spawn_valid, 1);
      checkOutput("holdX", spawn_x, capX);
      checkOutput("holdIdx", spawn_idx, capIdx);
    end
    spawn_ready = 1'b1;
    applyStimulus();
    checkOutput("holdAccept", spawn_count, prevAcc + 1);
    applyStimulus();
    checkOutput("holdAcceptOnce", spawn_count, prevAcc + 1);

    $display("[TB] x folding");
    rand_i = 32'd700;
    waitValid(400, "x700Timeout");
    checkOutput("x700", spawn_x, 188);
    applyStimulus();
    rand_i = 32'd599;
    waitValid(400, "x599Timeout");
    checkOutput("x599", spawn_x, 599);
    applyStimulus();

    $display("[TB] difficulty ramp");
    clear = 1'b1; applyStimulus(); clear = 1'b0;
    score = 24'd35;
    applyStimulus(); checkOutput("ramp56", interval, 56);
    applyStimulus(); checkOutput("ramp52", interval, 52);
    applyStimulus(); checkOutput("ramp48", interval, 48);
    applyStimulus(); checkOutput("rampHold48", interval, 48);
    score = 24'd200;
    repeat (25) applyStimulus();
    checkOutput("rampFloor", interval, 8);

    $display("[TB] clear during an offer");
    clear = 1'b1; score = 24'd0; applyStimulus(); clear = 1'b0;
    score = 24'd50;
    repeat (6) applyStimulus();
    checkOutput("interval40", interval, 40);
    spawn_ready = 1'b1;
    n = 0;
    while (mAccepted < 7 && n < 2500) begin
      applyStimulus();
      n++;
    end
    checkOutput("sevenSpawns", mAccepted, 7);
    spawn_ready = 1'b0;
    waitValid(400, "clearIssueTimeout");
    clear = 1'b1; applyStimulus(); clear = 1'b0;
    checkOutput("clrValid", spawn_valid, 0);
    checkOutput("clrCount", spawn_count, 0);
    checkOutput("clrInterval", interval, 60);
    score = 24'd0;

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      game_screen = ($urandom % 50) != 0;
      clear = ($urandom % 200) == 0;
      obj_active = OBJ_NUM'($urandom | $urandom);
      spawn_ready = ($urandom % 3) != 0;
      rand_i = $urandom;
      if ($urandom % 40 == 0) score = score + 24'($urandom % 20);
      applyStimulus();
    end

    $display("[TB] asynchronous reset mid-wait");
    game_screen = 1'b1; clear = 1'b0; obj_active = '0; spawn_ready = 1'b1;
    n = 0;
    while (mAccepted < 1 && n < 1000) begin
      applyStimulus();
      n++;
    end
    checkOutput("preResetCount", (mAccepted >= 1), 1);
    repeat (3) applyStimulus();
    #3;
    Reset_n = 1'b0;
    #1;
    checkResetValues("async");
    @(posedge Clk);
    #1;
    resetModel();
    Reset_n = 1'b1;
    repeat (20) applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/obstacle_spawn_scheduler.md
# obstacle_spawn_scheduler

Sequences asteroid spawning for the obstacle array. Once per video frame it counts toward a spawn interval and finds the lowest-index inactive obstacle slot. It then offers that slot, with a randomized position and speed, to the obstacle datapath over a valid/ready handshake. The spawn interval shrinks as the score rises. The block sits between the game state machine, the random-number PIO, the score counter and the obstacle module.

## Interface
Parameters:
- OBJ_NUM, 17, number of obstacle slots (max 32)
- INIT_INTERVAL, 60, frames between spawns after clear
- MIN_INTERVAL, 8, floor for the interval
- INTERVAL_STEP, 4, interval decrement per score level
- STEP_SCORE, 10, score points per level
- X_LIMIT, 600, spawn x must be below this value

Ports (clock and reset first):
- Clk, in, 1, system clock (50 MHz)
- Reset_n, in, 1, asynchronous active-low reset
- frame_clk, in, 1, VGA vertical sync (asynchronous to Clk, level signal)
- game_screen, in, 1, enables spawning
- clear, in, 1, synchronous clear (start screen or game over)
- obj_active, in, OBJ_NUM, slot i occupied when bit i is 1
- score, in, 24, current score (binary)
- rand, in, 32, free-running random word
- spawn_ready, in, 1, obstacle datapath accepts the spawn
- spawn_valid, out, 1, spawn request
- spawn_idx, out, 5, slot to activate
- spawn_x, out, 10, spawn x position
- spawn_xspeed, out, 3, horizontal speed, range 0..3
- spawn_yspeed, out, 3, vertical speed, range 1..4
- spawn_sign, out, 1, horizontal direction (1 = left)
- interval, out, 8, current spawn interval in frames
- spawn_count, out, 16, spawns accepted since clear

## Operation
- frame_clk passes through a 2-FF synchronizer. A rising-edge detect produces `tick`, a one-Clk pulse.
- FSM states: IDLE, WAIT, SCAN, ISSUE.
- IDLE: when game_screen=1, go to WAIT.
- WAIT:
  - Each tick increments `fcnt`; it saturates at 255.
  - When fcnt ≥ interval, go to SCAN.
- SCAN takes one cycle. A priority encoder selects the lowest i with obj_active[i]=0.
  - If a slot is free: latch the index and payload, then go to ISSUE.
  - If no slot is free: return to WAIT with fcnt unchanged, so the block rescans every 2 cycles until a slot frees.
- Payload, latched in SCAN from rand:
  - r = rand[9:0]; spawn_x = r if r < X_LIMIT, else r − 512.
  - spawn_xspeed = {1'b0, rand[14:13]}.
  - spawn_yspeed = {1'b0, rand[12:11]} + 1.
  - spawn_sign = rand[15].
- ISSUE:
  - spawn_valid=1. All spawn_* outputs hold stable until spawn_ready=1.
  - On the handshake cycle: fcnt ← 0, spawn_count += 1 (wraps at 16 bits), go to WAIT.
  - spawn_ready is ignored outside ISSUE.
- Difficulty:
  - Internal register thresh starts at STEP_SCORE.
  - On any cycle with score ≥ thresh: thresh += STEP_SCORE, and interval ← max(interval − INTERVAL_STEP, MIN_INTERVAL).
  - Only one step is taken per cycle, so a large score jump catches up over consecutive cycles.
  - This runs in every state except during clear.
- game_screen=0 in any state:
  - Go to IDLE and drop spawn_valid.
  - fcnt, interval, thresh and spawn_count are retained.
- clear=1 takes priority over everything:
  - state ← IDLE, spawn_valid ← 0, fcnt ← 0.
  - interval ← INIT_INTERVAL, thresh ← STEP_SCORE, spawn_count ← 0.
  - Dropping an in-flight request is legal.

## Timing
- Reset values (Reset_n=0):
  - State IDLE, spawn_valid 0, spawn_idx 0, spawn_x 0, spawn_xspeed 0, spawn_yspeed 0, spawn_sign 0.
  - interval = INIT_INTERVAL, spawn_count 0, fcnt 0, thresh = STEP_SCORE, synchronizer flops 0.
- tick fires on the 3rd Clk rising edge after frame_clk rises.
- Latency from the tick that makes fcnt = interval:
  - WAIT sees the compare on the next cycle and moves to SCAN.
  - SCAN → ISSUE on the following cycle.
  - spawn_valid rises 2 cycles after fcnt reaches interval.
- All outputs are registered.
- A slot freed in the same cycle SCAN samples obj_active is seen only on the next scan.
- Handshake completes in the cycle where spawn_valid & spawn_ready are both 1. spawn_valid falls on the next edge.
- No back-to-back spawns: at least interval ticks separate accepts. Exception: after a failed scan (all slots full), the next accept follows as soon as a slot frees.

## Test plan
- Reset, then game_screen=1, obj_active=0, spawn_ready=1, rand=32'h0000_A0C8 → after 60 ticks: spawn_idx=0, spawn_x=200, spawn_yspeed=1, spawn_xspeed=1, spawn_sign=1; spawn_count=1; the next spawn arrives 60 ticks later.
- obj_active all ones through 200 ticks → spawn_valid stays 0. Then clear bit 5 → spawn_valid=1 with spawn_idx=5 within 4 cycles.
- spawn_ready=0 for 50 cycles during ISSUE while rand changes every cycle → spawn_valid held high, payload constant. ready=1 → spawn_count increments once.
- rand[9:0]=10'd700 → spawn_x=188. rand[9:0]=10'd599 → spawn_x=599.
- score steps 0→35 in one cycle → interval goes 60→56→52→48 over 3 consecutive cycles. Raising score to 200 → interval saturates at 8.
- Assert clear during ISSUE with spawn_count=7 and interval=40 → next cycle: spawn_valid=0, spawn_count=0, interval=60, state IDLE. Reset_n low mid-WAIT → all outputs go to reset values immediately, without waiting for a clock edge.
